// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, key-size helper and the input loader
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int BLOCK_SIZE  = 128;
    localparam int WORD_SIZE   = 32;
    localparam int Nb          = 4;
    localparam int BLOCK_BYTES = (Nb * WORD_SIZE) / 8;

    // Key width in bits for a key of nk 32-bit words (nk = 4, 6 or 8).
    function automatic int key_size(input int nk);
        return nk * WORD_SIZE;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_BLOCK = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_byte_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : aes_byte_deserializer
// Description : Byte shift-in register. Each enabled byte enters at the
//               bottom, so after N bytes the first one sits in the top byte.
//               The output is the value the register will hold after the
//               current edge, which lets the owner commit a field on the
//               same edge that its final byte arrives.
// Ports       : clk, reset_n (async, active-low)
//               i_clear    - synchronous clear (wins over shift)
//               i_shift_en - shift i_data in this cycle
//               i_data     - byte to shift in
//               o_q_next   - post-edge register contents
// Revision    : 1.0 - initial release
// ============================================================================
module aes_byte_deserializer #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic [7:0]       i_data,
    output logic [WIDTH-1:0] o_q_next
);

    logic [WIDTH-1:0] r_q;

    always_comb begin
        o_q_next = r_q;
        if (i_clear) begin
            o_q_next = '0;
        end else if (i_shift_en) begin
            o_q_next = {r_q[WIDTH-9:0], i_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= o_q_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : aes_input_loader
// Description : Byte-serial front end for the AES core. Collects an optional
//               key (4*Nk bytes) and a 16-byte block from a valid/ready
//               stream, commits them to block_out/key, pulses start and then
//               holds off the stream until the cipher signals completion.
// Ports       : clk, reset_n (async, active-low)
//               s_data/s_valid/s_key_load/s_ready - byte stream in
//               block_out, key, key_valid       - committed cipher inputs
//               start, err                      - one-cycle pulses
//               cipher_done                     - cipher completion
// Parameter   : Nk - key length in 32-bit words (legal: 4, 6, 8)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_input_loader
    import aes_pkg::*;
#(
    parameter int  Nk       = 4,
    localparam int KEY_SIZE = key_size(Nk)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_key_load,
    output logic                  s_ready,
    output logic [BLOCK_SIZE-1:0] block_out,
    output logic [KEY_SIZE-1:0]   key,
    output logic                  key_valid,
    output logic                  start,
    input  logic                  cipher_done,
    output logic                  err
);

    // Counter value of the final byte in each field.
    localparam logic [4:0] c_KEY_LAST = 5'(4 * Nk - 1);
    localparam logic [4:0] c_BLK_LAST = 5'(BLOCK_BYTES - 1);

    loader_state_t r_state;
    loader_state_t w_state_next;
    logic [4:0]    r_cnt;
    logic [4:0]    w_cnt_next;

    logic                  r_key_frame;
    logic                  r_key_valid;
    logic                  r_start;
    logic                  r_err;
    logic [BLOCK_SIZE-1:0] r_block_out;
    logic [KEY_SIZE-1:0]   r_key;

    logic                  w_xfer;
    logic                  w_ready;
    logic                  w_key_shift;
    logic                  w_blk_shift;
    logic                  w_frame_first;
    logic                  w_frame_last;
    logic                  w_shadow_clear;
    logic [BLOCK_SIZE-1:0] w_blk_next;
    logic [KEY_SIZE-1:0]   w_key_next;

    assign w_xfer = s_valid && w_ready;

    // ------------------------------------------------------------------
    // Next-state, counter and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_ready        = 1'b0;
        w_key_shift    = 1'b0;
        w_blk_shift    = 1'b0;
        w_frame_first  = 1'b0;
        w_frame_last   = 1'b0;
        w_shadow_clear = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    w_frame_first = 1'b1;
                    w_cnt_next    = 5'd1;
                    if (s_key_load) begin
                        w_key_shift  = 1'b1;
                        w_state_next = ST_KEY;
                    end else begin
                        w_blk_shift  = 1'b1;
                        w_state_next = ST_BLOCK;
                    end
                end
            end

            ST_KEY: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    w_key_shift = 1'b1;
                    if (r_cnt == c_KEY_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_BLOCK;
                    end else begin
                        w_cnt_next = r_cnt + 5'd1;
                    end
                end
            end

            ST_BLOCK: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    w_blk_shift = 1'b1;
                    if (r_cnt == c_BLK_LAST) begin
                        w_frame_last = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_cnt_next = r_cnt + 5'd1;
                    end
                end
            end

            ST_ISSUE: begin
                // r_start already reflects whether this frame was accepted.
                w_shadow_clear = 1'b1;
                w_cnt_next     = '0;
                w_state_next   = r_start ? ST_WAIT : ST_IDLE;
            end

            ST_WAIT: begin
                if (cipher_done) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    aes_byte_deserializer #(
        .WIDTH (KEY_SIZE)
    ) u_key_shadow (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_shadow_clear),
        .i_shift_en (w_key_shift),
        .i_data     (s_data),
        .o_q_next   (w_key_next)
    );

    aes_byte_deserializer #(
        .WIDTH (BLOCK_SIZE)
    ) u_blk_shadow (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_shadow_clear),
        .i_shift_en (w_blk_shift),
        .i_data     (s_data),
        .o_q_next   (w_blk_next)
    );

    // ------------------------------------------------------------------
    // Commit: happens on the edge that takes the last block byte, so the
    // committed values are already stable while start is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_frame <= 1'b0;
            r_key_valid <= 1'b0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_block_out <= '0;
            r_key       <= '0;
        end else begin
            r_start <= 1'b0;
            r_err   <= 1'b0;
            if (w_frame_first) begin
                r_key_frame <= s_key_load;
            end
            if (w_frame_last) begin
                if (r_key_frame || r_key_valid) begin
                    r_block_out <= w_blk_next;
                    if (r_key_frame) begin
                        r_key <= w_key_next;
                    end
                    r_key_valid <= 1'b1;
                    r_start     <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign s_ready   = w_ready;
    assign block_out = r_block_out;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign start     = r_start;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_input_loader
// Description : Scoreboard bench for aes_input_loader, with one Nk=4 and one
//               Nk=8 instance, a frame-level reference model and a simple
//               cipher stand-in that answers start with cipher_done.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_input_loader;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;
    localparam int P_ERR   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n4, rst_n8;
    logic [7:0]   s_data4, s_data8;
    logic         s_valid4, s_valid8, s_key_load4, s_key_load8;
    logic         s_ready4, s_ready8;
    logic [127:0] blk4, blk8;
    logic [127:0] key4;
    logic [255:0] key8;
    logic         kv4, kv8, start4, start8, err4, err8, done4, done8;

    aes_input_loader #(.Nk(4)) u_dut4 (
        .clk(clk), .reset_n(rst_n4), .s_data(s_data4), .s_valid(s_valid4),
        .s_key_load(s_key_load4), .s_ready(s_ready4), .block_out(blk4),
        .key(key4), .key_valid(kv4), .start(start4), .cipher_done(done4),
        .err(err4)
    );

    aes_input_loader #(.Nk(8)) u_dut8 (
        .clk(clk), .reset_n(rst_n8), .s_data(s_data8), .s_valid(s_valid8),
        .s_key_load(s_key_load8), .s_ready(s_ready8), .block_out(blk8),
        .key(key8), .key_valid(kv8), .start(start8), .cipher_done(done8),
        .err(err8)
    );

    typedef struct {
        bit           is_err;
        logic [127:0] blk;
        logic [255:0] key;
        bit           kv;
        int           nbytes;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_err    = 0;

    int           phase[2];
    bit           start_seen[2];
    bit           level_mode[2];
    int           xfer_cnt[2];
    int           emu_cnt[2];
    bit           emu_pend[2];
    logic [255:0] mkey[2];
    logic [127:0] mblk[2];
    bit           mkv[2];
    logic [7:0]   frame_k[$];
    logic [7:0]   frame_b[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit rst_of(input int w);
        return (w == 0) ? rst_n4 : rst_n8;
    endfunction

    function automatic bit done_of(input int w);
        return (w == 0) ? done4 : done8;
    endfunction

    function automatic bit rdy_of(input int w);
        return (w == 0) ? s_ready4 : s_ready8;
    endfunction

    task automatic get_out(input int w, output logic st, output logic er, output logic rdy,
                           output logic kv, output logic [127:0] blk, output logic [255:0] ky);
        if (w == 0) begin
            st = start4; er = err4; rdy = s_ready4; kv = kv4; blk = blk4; ky = {128'b0, key4};
        end else begin
            st = start8; er = err8; rdy = s_ready8; kv = kv8; blk = blk8; ky = key8;
        end
    endtask

    task automatic set_in(input int w, input bit v, input logic [7:0] d, input bit kl);
        if (w == 0) begin
            s_valid4 = v; s_data4 = d; s_key_load4 = kl;
        end else begin
            s_valid8 = v; s_data8 = d; s_key_load8 = kl;
        end
    endtask

    // ------------------------------------------------------------------
    // Cipher stand-in: done rises a few cycles into WAIT. In level mode it
    // stays high until the first WAIT cycle of the next operation, so it is
    // still high while the loader sits in ISSUE.
    // ------------------------------------------------------------------
    task automatic emu_step(input int w);
        logic d;
        d = done_of(w);
        if (!rst_of(w)) begin
            d = 1'b0; emu_cnt[w] = 0; emu_pend[w] = 1'b0; start_seen[w] = 1'b0;
        end else if (start_seen[w]) begin
            start_seen[w] = 1'b0;
            emu_pend[w]   = 1'b1;
        end else if (emu_pend[w]) begin
            emu_pend[w] = 1'b0;
            if (level_mode[w]) d = 1'b0;
            emu_cnt[w] = int'($urandom_range(1, 6));
        end else if (emu_cnt[w] > 0) begin
            emu_cnt[w]--;
            if (emu_cnt[w] == 0) d = 1'b1;
        end else if (!level_mode[w]) begin
            d = 1'b0;
        end
        if (w == 0) done4 = d; else done8 = d;
    endtask

    initial begin
        done4 = 1'b0; done8 = 1'b0;
        forever begin
            @(negedge clk);
            emu_step(0);
            emu_step(1);
        end
    end

    // Count accepted bytes: inputs and s_ready are stable mid-low-phase.
    initial begin
        xfer_cnt[0] = 0; xfer_cnt[1] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n4) xfer_cnt[0] = 0;
            else if (s_valid4 && s_ready4) xfer_cnt[0]++;
            if (!rst_n8) xfer_cnt[1] = 0;
            else if (s_valid8 && s_ready8) xfer_cnt[1]++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on start/err and tracks ready timing.
    // ------------------------------------------------------------------
    task automatic mon(input int w);
        logic st, er, rdy, kv;
        logic [127:0] blk;
        logic [255:0] ky;
        exp_t e;
        bit   have;
        get_out(w, st, er, rdy, kv, blk, ky);
        if (!rst_of(w)) begin
            phase[w] = P_IDLE;
            return;
        end
        case (phase[w])
            P_ISSUE: begin
                chk($sformatf("ready_low_after_start%0d", w), {255'b0, rdy}, 256'd0);
                phase[w] = P_WAIT;
            end
            P_WAIT: begin
                if (done_of(w)) begin
                    chk($sformatf("ready_after_done%0d", w), {255'b0, rdy}, 256'd1);
                    phase[w] = P_IDLE;
                end else begin
                    chk($sformatf("ready_low_in_wait%0d", w), {255'b0, rdy}, 256'd0);
                end
            end
            P_ERR: begin
                chk($sformatf("ready_after_err%0d", w), {255'b0, rdy}, 256'd1);
                phase[w] = P_IDLE;
            end
            default: ;
        endcase
        if (st || er) begin
            have = (w == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            if (!have) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_pulse%0d: got start=%0b err=%0b required none", w, st, er);
            end else begin
                e = (w == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("start%0d", w), {255'b0, st}, {255'b0, !e.is_err});
                chk($sformatf("err%0d", w), {255'b0, er}, {255'b0, e.is_err});
                chk($sformatf("block_out%0d", w), {128'b0, blk}, {128'b0, e.blk});
                chk($sformatf("key%0d", w), ky, e.key);
                chk($sformatf("key_valid%0d", w), {255'b0, kv}, {255'b0, e.kv});
                chk($sformatf("bytes_consumed%0d", w), 256'(xfer_cnt[w]), 256'(e.nbytes));
                chk($sformatf("ready_in_issue%0d", w), {255'b0, rdy}, 256'd0);
            end
            xfer_cnt[w] = 0;
            phase[w]    = er ? P_ERR : P_ISSUE;
            if (st) start_seen[w] = 1'b1;
        end
    endtask

    initial begin
        phase[0] = P_IDLE; phase[1] = P_IDLE;
        forever begin
            @(posedge clk);
            #1;
            mon(0);
            mon(1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive_byte(input int w, input logic [7:0] b, input bit kl, input int gap);
        int budget;
        budget = 0;
        while (int'($urandom_range(0, 99)) < gap) begin
            set_in(w, 1'b0, 8'($urandom), 1'($urandom));
            @(negedge clk);
        end
        set_in(w, 1'b1, b, kl);
        while (!rdy_of(w) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!rdy_of(w)) begin
            n_checks++; n_err++;
            $display("FAIL handshake_timeout%0d: got s_ready=0 required 1 within 300 cycles", w);
        end
        @(negedge clk);
    endtask

    // Frame-level model: a frame starts the cipher if it carries a key or a
    // key is already held; otherwise it is an error and nothing changes.
    task automatic send_frame(input int w, input bit kl, input int gap);
        logic [255:0] kval;
        logic [127:0] bval;
        exp_t e;
        int   idx;
        kval = '0;
        bval = '0;
        if (kl) foreach (frame_k[i]) kval = {kval[247:0], frame_k[i]};
        foreach (frame_b[i]) bval = {bval[119:0], frame_b[i]};
        e.nbytes = (kl ? frame_k.size() : 0) + frame_b.size();
        if (kl || mkv[w]) begin
            if (kl) mkey[w] = kval;
            mblk[w]  = bval;
            mkv[w]   = 1'b1;
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.blk = mblk[w];
        e.key = mkey[w];
        e.kv  = mkv[w];
        if (w == 0) sb0.push_back(e); else sb1.push_back(e);
        idx = 0;
        if (kl) begin
            foreach (frame_k[i]) begin
                drive_byte(w, frame_k[i], (idx == 0) ? kl : 1'($urandom), gap);
                idx++;
            end
        end
        foreach (frame_b[i]) begin
            drive_byte(w, frame_b[i], (idx == 0) ? kl : 1'($urandom), gap);
            idx++;
        end
        set_in(w, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic fill_key_seq(input int n);
        frame_k.delete();
        for (int i = 0; i < n; i++) frame_k.push_back(8'(i));
    endtask

    task automatic fill_key_rand(input int n);
        frame_k.delete();
        for (int i = 0; i < n; i++) frame_k.push_back(8'($urandom));
    endtask

    task automatic fill_blk_rand();
        frame_b.delete();
        for (int i = 0; i < 16; i++) frame_b.push_back(8'($urandom));
    endtask

    task automatic check_reset(input int w);
        logic st, er, rdy, kv;
        logic [127:0] blk;
        logic [255:0] ky;
        get_out(w, st, er, rdy, kv, blk, ky);
        chk($sformatf("rst_ready%0d", w), {255'b0, rdy}, 256'd1);
        chk($sformatf("rst_block%0d", w), {128'b0, blk}, 256'd0);
        chk($sformatf("rst_key%0d", w), ky, 256'd0);
        chk($sformatf("rst_key_valid%0d", w), {255'b0, kv}, 256'd0);
        chk($sformatf("rst_start%0d", w), {255'b0, st}, 256'd0);
        chk($sformatf("rst_err%0d", w), {255'b0, er}, 256'd0);
    endtask

    task automatic wait_idle(input int w);
        int budget;
        budget = 0;
        while (((w == 0 ? sb0.size() : sb1.size()) > 0 || phase[w] != P_IDLE) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (budget >= 1000) begin
            n_err++;
            $display("FAIL idle_timeout%0d: got %0d pending required 0", w,
                     (w == 0) ? sb0.size() : sb1.size());
        end
    endtask

    task automatic model_reset(input int w);
        mkey[w] = '0; mblk[w] = '0; mkv[w] = 1'b0;
    endtask

    initial begin
        rst_n4 = 1'b0; rst_n8 = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        level_mode[0] = 1'b0; level_mode[1] = 1'b0;
        model_reset(0); model_reset(1);
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_n4 = 1'b1; rst_n8 = 1'b1;
        @(negedge clk);

        // Block frame with no key yet held: err, nothing committed.
        fill_blk_rand();
        send_frame(0, 1'b0, 0);

        // Known-answer key frame, continuous valid.
        fill_key_seq(16);
        frame_b.delete();
        for (int i = 0; i < 16; i++) frame_b.push_back(8'(i * 17));
        send_frame(0, 1'b1, 0);

        // Block-only frame of 0xFF reusing the key.
        frame_b.delete();
        for (int i = 0; i < 16; i++) frame_b.push_back(8'hff);
        send_frame(0, 1'b0, 0);

        // Level-style done held across ISSUE, random frames with gaps.
        level_mode[0] = 1'b1;
        for (int f = 0; f < 5; f++) begin
            fill_key_rand(16);
            fill_blk_rand();
            send_frame(0, 1'($urandom), 30);
        end
        wait_idle(0);
        level_mode[0] = 1'b0;
        wait_idle(0);

        // Reset after 10 key bytes, then a block frame must give err.
        fill_key_rand(16);
        for (int i = 0; i < 10; i++) drive_byte(0, frame_k[i], (i == 0) ? 1'b1 : 1'b0, 0);
        rst_n4 = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        model_reset(0);
        @(negedge clk);
        check_reset(0);
        rst_n4 = 1'b1;
        @(negedge clk);
        check_reset(0);
        fill_blk_rand();
        send_frame(0, 1'b1 ^ 1'b1, 0);
        wait_idle(0);

        // Nk=8: 32-byte key with random valid gaps, then reuse and a level-done run.
        fill_key_seq(32);
        fill_blk_rand();
        send_frame(1, 1'b1, 40);
        fill_blk_rand();
        send_frame(1, 1'b0, 20);
        level_mode[1] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill_key_rand(32);
            fill_blk_rand();
            send_frame(1, 1'($urandom), 25);
        end
        wait_idle(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/aes_input_loader.md
# aes_input_loader

Byte-serial front end for the AES core. Accepts key and plaintext bytes over a valid/ready stream, assembles them MSB-first into the 128-bit block and `KEY_SIZE`-bit key, and issues a one-cycle `start` to the cipher. It then back-pressures the stream until the cipher reports completion. It sits directly upstream of the AES top and drives that block's `in` and `key` inputs.

## Interface
Parameters:
- `Nk`, 4, key length in 32-bit words; legal values 4, 6, 8. `KEY_SIZE = 32*Nk`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` valid.
- `s_key_load` in 1: sampled with the first byte of a frame; 1 = key frame, 0 = block-only frame.
- `s_ready` out 1: loader can accept a byte.
- `block_out` out 128: plaintext to cipher `in`.
- `key` out `KEY_SIZE`: key to key expansion.
- `key_valid` out 1: a key has been committed since reset.
- `start` out 1: one-cycle pulse; cipher begins on `block_out`/`key`.
- `cipher_done` in 1: cipher completion, pulse or level.
- `err` out 1: one-cycle pulse; block frame received with no valid key.

## Operation
- Transfer occurs on any cycle with `s_valid && s_ready`.
- **Key frame** (`s_key_load`=1 on the first byte): 4*Nk key bytes, then 16 block bytes.
- **Block frame** (`s_key_load`=0 on the first byte): 16 block bytes. The current key is reused.
- `s_key_load` is ignored on every byte other than the first of a frame.
- Byte order: the first byte lands in the top byte, bits [W-1:W-8], of its field, per FIPS-197 byte 0.
- Bytes shift into internal shadow registers. `block_out` and `key` change only at commit, so they stay stable for the whole cipher operation.
- FSM states:
  - **IDLE**: `s_ready`=1. On the first transfer, go to KEY (key frame) or BLOCK (block frame). The first byte is stored and the byte counter is set to 1.
  - **KEY**: `s_ready`=1. After byte 4*Nk is accepted, clear the counter and go to BLOCK.
  - **BLOCK**: `s_ready`=1. After byte 16 is accepted, go to ISSUE.
  - **ISSUE**, one cycle, `s_ready`=0:
    - If the frame was a key frame or `key_valid`=1: commit `block_out`, commit `key` (key frames only), set `key_valid`, pulse `start`, then go to WAIT.
    - Otherwise: pulse `err`, commit nothing, no `start`, then go to IDLE.
  - **WAIT**: `s_ready`=0. When `cipher_done`=1 is sampled, go to IDLE.
- Byte counter: 5 bits, counting 0..31, cleared on every state change.

## Timing
- Reset values: `s_ready`=1 (IDLE); `block_out`=0; `key`=0; `key_valid`=0; `start`=0; `err`=0; counter=0.
- Latency: `start` is high in the cycle after the last block byte transfers.
- `s_ready` drops in that same cycle and stays low until the cycle after `cipher_done` is sampled in WAIT.
- `cipher_done` is ignored outside WAIT, including in the ISSUE cycle. A level `done` that is still high from the previous operation must not cause an early exit. WAIT is entered one cycle after `start`, and the cipher core clears `done` on `start`.
- Minimum frame throughput: 16 bytes + ISSUE + WAIT cycles. There are no gaps while `s_ready`=1.
- `s_valid` low mid-frame stalls the frame indefinitely. There is no timeout.
- Reset asserted mid-frame or in WAIT: immediately return to IDLE; clear `key_valid`; discard the partial frame. The committed `key`/`block_out` reset to 0.
- A key frame whose block portion is interrupted by reset commits nothing.

## Structure
- Shared package `aes_pkg`:
  - `BLOCK_SIZE`=128, `WORD_SIZE`=32, `Nb`=4.
  - Key-size function of Nk.
  - Loader state enum (IDLE, KEY, BLOCK, ISSUE, WAIT).
- One sub-module, `aes_byte_deserializer #(WIDTH)`: byte shift-in register with shift enable and synchronous clear. It is instantiated once for the key shadow and once for the block shadow.
- The FSM, counter and commit logic live in `aes_input_loader`.

## Test plan
- **Basic key frame:** reset, then a key frame with key 000102…0f and block 00112233445566778899aabbccddeeff, Nk=4, `s_valid` continuous.
  - `key`=000102030405060708090a0b0c0d0e0f; `block_out` equals the block; `key_valid`=1.
  - `start` is high exactly 1 cycle, the cycle after byte 32.
  - `s_ready`=0 until `cipher_done`.
- **Block-only frame, key reuse:** after the above, `cipher_done` pulses, then a block-only frame of 16×0xFF.
  - `block_out`=all-FF; `key` unchanged; one `start`.
  - Ciphertext seen downstream is consistent with the reused key.
- **Block frame without a key:** block-only frame straight after reset.
  - `err` pulses 1 cycle; no `start`; `key_valid`=0; `block_out`=0.
  - `s_ready` returns to 1 the next cycle.
- **Nk=8 with stalls:** key frame with random `s_valid` gaps.
  - Exactly 32 key bytes then 16 block bytes are consumed.
  - `key`=000102…1f; the block matches.
- **Back-pressure and stale done:** `cipher_done` held high through ISSUE.
  - The loader leaves WAIT only on the first WAIT-cycle sample.
  - Bytes presented while `s_ready`=0 are not consumed (scoreboard count).
- **Reset mid-frame:** assert `reset_n`=0 after 10 key bytes, then release and send a full block frame.
  - All outputs are at reset values after reset.
  - The subsequent block-only frame produces `err`.
